// File: rtl/bit_stuffer.sv
// Serial bit stuffer: after RUN_LEN consecutive data 1s, inserts one 0 bit,
// stalling the source for the cycle that bit occupies. Output is registered.
module bit_stuffer #(
    parameter int RUN_LEN = 6,
    parameter int STAT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout,
    output logic              dout_valid,
    output logic              stuff_flag,
    output logic [STAT_W-1:0] stuff_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        STUFF = 1'b1
    } state_t;

    localparam logic [3:0]        LAST_ONE = 4'(RUN_LEN - 1);
    localparam logic [STAT_W-1:0] CNT_ONE  = STAT_W'(1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_dout;
    logic              r_dout_valid;
    logic              r_stuff_flag;
    logic [STAT_W-1:0] r_stuff_cnt;
    logic              w_xfer;

    assign din_ready  = en & (r_state == RUN);
    assign w_xfer     = din_valid & din_ready;

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign stuff_flag = r_stuff_flag;
    assign stuff_cnt  = r_stuff_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= RUN;
            r_cnt        <= 4'd0;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
            r_stuff_flag <= 1'b0;
            r_stuff_cnt  <= '0;
        end else if (!en) begin
            // Disabling drops any pending stuff bit and restarts the run.
            r_state      <= RUN;
            r_cnt        <= 4'd0;
            r_dout_valid <= 1'b0;
            r_stuff_flag <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_stuff_flag <= 1'b0;
                    if (w_xfer) begin
                        r_dout       <= din;
                        r_dout_valid <= 1'b1;
                        if (!din) begin
                            r_cnt <= 4'd0;
                        end else if (r_cnt == LAST_ONE) begin
                            r_cnt   <= 4'd0;
                            r_state <= STUFF;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end else begin
                        // Idle cycles keep the run count so gaps don't break a run.
                        r_dout_valid <= 1'b0;
                    end
                end
                STUFF: begin
                    r_dout       <= 1'b0;
                    r_dout_valid <= 1'b1;
                    r_stuff_flag <= 1'b1;
                    r_stuff_cnt  <= r_stuff_cnt + CNT_ONE;
                    r_state      <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_stuffer.sv
// Directed bench for bit_stuffer: a default instance plus a STAT_W=2 instance
// sharing the same stimulus so counter wrap can be observed.
module tb_bit_stuffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       din;
    logic       din_valid;
    logic       din_ready;
    logic       dout;
    logic       dout_valid;
    logic       stuff_flag;
    logic [7:0] stuff_cnt;
    logic       din_ready2;
    logic       dout2;
    logic       dout_valid2;
    logic       stuff_flag2;
    logic [1:0] stuff_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bit_stuffer #(.RUN_LEN(6), .STAT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .stuff_flag(stuff_flag), .stuff_cnt(stuff_cnt)
    );

    bit_stuffer #(.RUN_LEN(6), .STAT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .din_ready(din_ready2), .dout(dout2), .dout_valid(dout_valid2),
        .stuff_flag(stuff_flag2), .stuff_cnt(stuff_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check din_ready before the edge, outputs after it.
    task automatic cycle(input string tag, input logic e, input logic v, input logic d,
                         input logic er, input logic ev, input logic ed, input logic ef);
        en = e; din_valid = v; din = d;
        #1;
        chk({tag, ".din_ready"}, 32'(din_ready), 32'(er));
        @(posedge clk);
        #1;
        chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(ev));
        chk({tag, ".dout"}, 32'(dout), 32'(ed));
        chk({tag, ".stuff_flag"}, 32'(stuff_flag), 32'(ef));
        $display("[TB] %s en=%0b v=%0b din=%0b -> rdy=%0b dv=%0b dout=%0b sf=%0b cnt=%0d cnt2=%0d",
                 tag, e, v, d, er, dout_valid, dout, stuff_flag, stuff_cnt, stuff_cnt2);
    endtask

    task automatic do_reset();
        en = 1'b0; din_valid = 1'b0; din = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst.dout_valid", 32'(dout_valid), 0);
        chk("rst.stuff_cnt", 32'(stuff_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic six_ones(input string tag);
        for (int i = 0; i < 6; i++) cycle(tag, 1, 1, 1, 1, 1, 1, 0);
    endtask

    initial begin
        logic t3_bits [8];
        logic [1:0] t6_exp2 [5];
        t3_bits = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        t6_exp2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // T1: reset held with random data, en low
        rst = 1'b0; en = 1'b0; din = 1'b0; din_valid = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            cycle("T1", 0, 1'($urandom), 1'($urandom), 0, 0, 0, 0);
            chk("T1.stuff_cnt", 32'(stuff_cnt), 0);
            chk("T1.stuff_cnt2", 32'(stuff_cnt2), 0);
        end
        rst = 1'b1;

        // T2: eight 1s, stuff after the sixth
        six_ones("T2");
        cycle("T2.stuff", 1, 1, 1, 0, 1, 0, 1);
        chk("T2.stuff_cnt", 32'(stuff_cnt), 1);
        cycle("T2.b7", 1, 1, 1, 1, 1, 1, 0);
        cycle("T2.b8", 1, 1, 1, 1, 1, 1, 0);
        cycle("T2.off", 0, 1, 1, 0, 0, 1, 0);

        // T3: run of five then a 0 -> passthrough
        do_reset();
        for (int i = 0; i < 8; i++) cycle("T3", 1, 1, t3_bits[i], 1, 1, t3_bits[i], 0);
        chk("T3.stuff_cnt", 32'(stuff_cnt), 0);
        cycle("T3.off", 0, 0, 0, 0, 0, 1, 0);

        // T4: six 1s separated by 3-cycle valid gaps
        for (int k = 0; k < 6; k++) begin
            cycle("T4.bit", 1, 1, 1, 1, 1, 1, 0);
            if (k < 5)
                for (int g = 0; g < 3; g++) cycle("T4.gap", 1, 0, 0, 1, 0, 1, 0);
        end
        cycle("T4.stuff", 1, 0, 0, 0, 1, 0, 1);
        cycle("T4.idle", 1, 0, 0, 1, 0, 0, 0);
        chk("T4.stuff_cnt", 32'(stuff_cnt), 1);

        // T5: en dropped in STUFF cycle, then a fresh run is required
        six_ones("T5");
        cycle("T5.drop", 0, 1, 1, 0, 0, 1, 0);
        chk("T5.stuff_cnt", 32'(stuff_cnt), 1);
        six_ones("T5.re");
        cycle("T5.stuff", 1, 1, 0, 0, 1, 0, 1);
        cycle("T5.zero", 1, 1, 0, 1, 1, 0, 0);
        chk("T5.stuff_cnt2", 32'(stuff_cnt), 2);

        // Asynchronous reset while a stuff is pending
        six_ones("TR");
        #3;
        rst = 1'b0;
        #1;
        chk("TR.dout_valid", 32'(dout_valid), 0);
        chk("TR.stuff_flag", 32'(stuff_flag), 0);
        chk("TR.dout", 32'(dout), 0);
        chk("TR.stuff_cnt", 32'(stuff_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle("TR.after", 1, 0, 0, 1, 0, 0, 0);

        // T6: five stuff events, STAT_W=2 counter wraps
        for (int k = 0; k < 5; k++) begin
            six_ones("T6");
            cycle("T6.stuff", 1, 0, 0, 0, 1, 0, 1);
            chk("T6.stuff_cnt2", 32'(stuff_cnt2), 32'(t6_exp2[k]));
            chk("T6.stuff_cnt", 32'(stuff_cnt), 32'(k + 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
